// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM states and width helpers.
// Used by the transmitter and the future receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_cfg_if.sv
// uart_tx_fifo_cfg_if: producer-side push handshake
// for the UART transmit FIFO.
interface uart_tx_fifo_cfg_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data_in;
  logic                 valid;
  logic                 ready;

  modport master (
    output data_in,
    output valid,
    input  ready
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: small synchronous FIFO, power-of-two depth,
// registered occupancy plus its next value.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [occ_w(DEPTH)-1:0]   count,
  output logic [occ_w(DEPTH)-1:0]   count_nxt
);

  localparam int AW = cnt_w(DEPTH);
  localparam int CW = occ_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  assign rdata     = mem_q[rd_q];
  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: configurable-frame UART transmitter
// fed by an internal FIFO; frames go out back-to-back.
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  uart_tx_fifo_cfg_if.slave              bus,
  output logic                           tx,
  output logic                           busy,
  output logic                           overflow,
  output logic [occ_w(FIFO_DEPTH)-1:0]   fifo_count
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BW       = cnt_w(BAUD_DIV);
  localparam int CW       = occ_w(FIFO_DEPTH);

  localparam logic [BW-1:0] BAUD_MAX  = BW'(BAUD_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
    $error("uart_tx_fifo_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo_cfg: STOP_BITS must be 1 or 2");
  end
  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo_cfg: BAUD_DIV must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo_cfg: FIFO_DEPTH must be a power of two >= 2");
  end

  logic                 push, pop, full, empty;
  logic [DATA_BITS-1:0] rdata;
  logic [CW-1:0]        cnt_nxt;

  assign bus.ready = ~full;
  assign push      = bus.valid & ~full;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .wdata     (bus.data_in),
    .rdata     (rdata),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count),
    .count_nxt (cnt_nxt)
  );

  tx_state_t            state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;
  logic                 tick;

  assign tick = (baud_q == BAUD_MAX);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) baud_d = tick ? '0 : baud_q + 1'b1;
    unique case (state_q)
      S_IDLE: pop = ~empty;
      S_START: if (tick) begin
        state_d = S_DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      S_DATA: if (tick) begin
        if (bit_q != DATA_LAST) begin
          bit_d   = bit_q + 1'b1;
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          tx_d    = shift_q[1];
        end else if (PARITY != PAR_NONE) begin
          state_d = S_PARITY;
          tx_d    = par_q;
        end else begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_PARITY: if (tick) begin
        state_d = S_STOP;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
      S_STOP: if (tick) begin
        if (bit_q != STOP_LAST) bit_d = bit_q + 1'b1;
        else if (!empty)        pop   = 1'b1;
        else begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A pop always starts a new frame, from idle or straight out of stop.
    if (pop) begin
      state_d = S_START;
      baud_d  = '0;
      shift_d = rdata;
      par_d   = (PARITY == PAR_EVEN) ? ^rdata : ~^rdata;
      tx_d    = 1'b0;
    end
  end

  assign busy_d = (state_d != S_IDLE) || (cnt_nxt != '0);
  assign ovf_d  = bus.valid & full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule
